// File: rtl/acc_copy_pkg.sv
// Shared types and constants for the word-copy RAM master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package acc_copy_pkg;

    // Copy engine sequencing: one read, a fixed read-latency wait, one write per word.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Accelerator window bounds; the RAM wrapper decodes the same range.
    localparam logic [15:0] ACC_WIN_LO = 16'h0400;
    localparam logic [15:0] ACC_WIN_HI = 16'h0C00;

endpackage

// File: rtl/acc_copy_master.sv
// Copies len_i words from src to dst through the single-port RAM, one read then one write per word.
// Latency: first read one cycle after start, RD_LATENCY+2 cycles per word, done_o one cycle after the last write.
// Backpressure: none; the RAM accepts every request, abort_i cancels and start_i is ignored while busy.
module acc_copy_master
    import acc_copy_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [ADDR_WIDTH-1:0]   src_addr_i,
    input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
    input  logic [LEN_WIDTH-1:0]    len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [LEN_WIDTH-1:0]    words_o,
    output logic                    mem_en_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int CW = $clog2(RD_LATENCY + 1);
    localparam int BW = DATA_WIDTH / 8;
    // Wait counter counts down to zero; zero marks the cycle the read data is valid.
    localparam logic [CW-1:0] LAT_LAST = CW'(RD_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   src_q, src_d;
    logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    words_q, words_d;
    logic [LEN_WIDTH-1:0]    words_inc;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;
    logic [BW-1:0]           mem_be_q, mem_be_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    // Next-state logic, then every registered output derived from the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        words_d     = words_q;
        err_d       = err_q;
        mem_wdata_d = mem_wdata_q;
        words_inc   = words_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if ((src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00)) begin
                        err_d = 1'b1;
                    end else if (len_i == '0) begin
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        src_d   = src_addr_i;
                        dst_d   = dst_addr_i;
                        len_d   = len_i;
                        err_d   = 1'b0;
                        words_d = '0;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = LAT_LAST;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    mem_wdata_d = mem_rdata_i;
                    state_d     = ST_WR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR: begin
                // The write on the bus completes regardless; abort only stops what follows.
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    words_d = words_inc;
                    src_d   = src_q + ADDR_WIDTH'(4);
                    dst_d   = dst_q + ADDR_WIDTH'(4);
                    state_d = (words_inc == len_q) ? ST_DONE : ST_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d == ST_RD) || (state_d == ST_WAIT) || (state_d == ST_WR);
        done_d     = (state_d == ST_DONE);
        mem_en_d   = (state_d == ST_RD) || (state_d == ST_WR);
        mem_we_d   = (state_d == ST_WR);
        mem_be_d   = (state_d == ST_WR) ? {BW{1'b1}} : {BW{1'b0}};
        mem_addr_d = (state_d == ST_RD) ? src_d :
                     (state_d == ST_WR) ? dst_d : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            words_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            words_q     <= words_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign words_o     = words_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
